// File: rtl/prism_cfg_pkg.sv
// Shared types and defaults for the PRISM configuration sequencer.
// The state encoding matches the values software sees when debugging the block.
package prism_cfg_pkg;

   localparam int DEFAULT_AW    = 6;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DATA_W        = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_LOAD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   // A queued entry packs the target address above the write data.
   function automatic int entry_width(input int aw);
      return aw + DATA_W;
   endfunction

endpackage

// File: rtl/prism_cfg_fifo.sv
// Show-ahead synchronous FIFO holding queued {addr,data} register writes.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module prism_cfg_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/prism_cfg_sequencer.sv
// Halts PRISM, drains queued register writes into its debug port, then re-enables it.
// Outside the drain the host bus passes straight through to the debug port.
module prism_cfg_sequencer
   import prism_cfg_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int HALT_CYCLES = 2,
   parameter int AW          = DEFAULT_AW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [AW-1:0]          host_addr,
   input  logic [31:0]            host_wdata,
   input  logic                   host_wr,
   input  logic                   host_rd,
   output logic [31:0]            host_rdata,
   output logic                   host_ready,
   input  logic                   q_push,
   input  logic [AW-1:0]          q_addr,
   input  logic [31:0]            q_data,
   output logic                   q_full,
   output logic [$clog2(DEPTH):0] q_count,
   input  logic                   start,
   input  logic                   abort,
   output logic [AW-1:0]          prism_addr,
   output logic                   prism_wr,
   output logic [31:0]            prism_wdata,
   input  logic [31:0]            prism_rdata,
   output logic                   prism_reset,
   output logic                   prism_enable,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow
);

   localparam int EW = entry_width(AW);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int HW = $clog2(HALT_CYCLES + 1);

   state_t         state, state_next;
   logic [HW-1:0]  halt_cnt, halt_next;
   logic           hold_reset;
   logic           done_q;
   logic           overflow_q;
   logic           q_empty;
   logic           loading;
   logic           pop_fire;
   logic           start_ok;
   logic [EW-1:0]  head;

   assign loading  = (state == ST_LOAD);
   assign pop_fire = loading && !q_empty;
   assign start_ok = start && !abort && (state == ST_IDLE || state == ST_RUN);

   prism_cfg_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push),
      .pop   (loading),
      .flush (abort),
      .wdata ({q_addr, q_data}),
      .rdata (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         halt_cnt   <= '0;
         hold_reset <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state    <= state_next;
         halt_cnt <= halt_next;
         done_q   <= (state == ST_RELEASE) && !abort;
         if (abort)         hold_reset <= 1'b1;
         else if (start_ok) hold_reset <= 1'b0;
         if (start_ok)                                overflow_q <= 1'b0;
         else if (q_push && q_full && !pop_fire)      overflow_q <= 1'b1;
      end
   end

   // Leave LOAD once the entry popping now is the last one and nothing new arrives.
   always_comb begin
      state_next = state;
      halt_next  = halt_cnt;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_RUN: begin
               if (start) begin
                  state_next = ST_HALT;
                  halt_next  = HW'(HALT_CYCLES - 1);
               end
            end
            ST_HALT: begin
               if (halt_cnt == '0) state_next = q_empty ? ST_RELEASE : ST_LOAD;
               else                halt_next  = halt_cnt - HW'(1);
            end
            ST_LOAD: begin
               if (q_empty || (q_count == CW'(1) && !q_push)) state_next = ST_RELEASE;
            end
            ST_RELEASE: state_next = ST_RUN;
            default:    state_next = ST_IDLE;
         endcase
      end
   end

   assign host_ready   = !loading;
   assign host_rdata   = prism_rdata;
   assign prism_addr   = loading ? head[EW-1:32] : host_addr;
   assign prism_wdata  = loading ? head[31:0]    : host_wdata;
   assign prism_wr     = loading ? pop_fire      : host_wr;
   assign prism_reset  = (state == ST_HALT) || loading || (state == ST_IDLE && hold_reset);
   assign prism_enable = (state == ST_RUN);
   assign busy         = (state == ST_HALT) || loading || (state == ST_RELEASE);
   assign done         = done_q;
   assign overflow     = overflow_q;

endmodule
